xorshift_step_scheduler: RTL and testbench
==========================================

// Module: xorshift_step_scheduler
// PURPOSE
//  Sequences one xorshift32 PRNG datapath: loads a 6-bit seed, runs warm-up rounds, then advances it
//  on a periodic tick and on demand. Shares the generator round-robin between two requesters, one
//  step per grant. Drives the 7-segment hex digit of state[3:0] for the TinyTapeout-style top.
// PARAMETERS
//  MAX_COUNT      10_000_000  RUN-state cycles between auto-steps (>=2); benches use 100
//  WARMUP_ROUNDS  8           steps taken after a seed load before RUN (>=1)
// PORTS
//  clk        in   1   single clock; all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  seed       in   6   seed, sampled in LOAD
//  reseed     in   1   1-cycle pulse in RUN: restart LOAD/WARMUP; ignored elsewhere
//  req        in   2   level request per requester; held until its gnt is seen
//  gnt        out  2   registered one-hot 1-cycle grant
//  rnd        out  32  value produced by the granted step; valid while gnt!=0
//  busy       out  1   1 when FSM != RUN
//  segments   out  7   active-high {g,f,e,d,c,b,a} hex of state[3:0]
// BEHAVIOUR
//  - Step: x^=x<<13; x^=x>>17; x^=x<<5 (32-bit, shifts drop bits). Max one step per cycle.
//  - Seed expansion: state <= {SEED_PAD=26'h2545F49, seed}; never zero (zero is a fixed point).
//  - Reset values: FSM=LOAD, state=0, gnt=0, rnd=0, segments=0 (blank), tick_cnt=0, rr_ptr=0, busy=1.
//  - FSM: LOAD (1 cycle, load seed) -> WARMUP (WARMUP_ROUNDS cycles, 1 step each) -> RUN.
//    RUN + reseed -> LOAD. rst at any point -> LOAD next cycle; in-flight gnt dropped.
//  - tick_cnt: counts only in RUN, 0..MAX_COUNT-1. Wrap cycle = tick -> one step.
//    Cleared on LOAD. First tick: MAX_COUNT cycles after entering RUN.
//  - Arbitration (RUN only): req sampled cycle N. Grant winner steps state at edge N.
//    gnt[w]=1 and rnd=next state in cycle N+1 (latency 1).
//  - Round-robin: both requesting -> requester rr_ptr wins; rr_ptr <= ~winner after each grant.
//  - req[i] is ignored while gnt[i]=1, so one held request gets exactly one grant.
//  - Tick and grant in the same cycle: one step; the requester gets that value; the tick is consumed.
//  - reseed and req in the same cycle: reseed wins, no grant. Requests pending outside RUN wait, no loss.
//  - segments: registered hex decode of the post-step state[3:0]; updates on every step, including
//    WARMUP; blank until the first step.
//  - rnd holds its last value when gnt=0.
// STRUCTURE
//  - Package xs_sched_pkg: FSM enum {LOAD,WARMUP,RUN}, SEED_PAD, 16-entry hex->7seg table.
//  - Sub-module xorshift32_next: combinational 32-in/32-out step, instantiated once.
//  - Controller top: FSM, tick counter, warm-up counter, arbiter, output registers.
// TESTING (golden C/Python xorshift32 model)
//  - Reset, seed=0: LOAD loads 32'h9517D240; busy=1 for 1+8 cycles.
//    Next cycle: busy=0 and state = 8 model steps. segments=0 throughout reset.
//  - RUN, MAX_COUNT=100, no req: exactly one step per 100 cycles over 1000 cycles.
//    segments tracks model state[3:0].
//  - req=2'b11 held until granted: gnt=01 then 10 on successive cycles.
//    rnd = model steps k+1 and k+2; req=2'b01 held 4 cycles -> gnt[0] on cycles 2 and 4 only.
//  - req[1] raised on the tick-wrap cycle: single step; gnt[1] carries it; next tick 100 cycles later.
//  - reseed with seed=6'h3F mid-RUN while req=01: no grant; state=32'h9517D27F.
//    busy for 9 cycles, then req served.
//  - rst asserted the cycle gnt would fire: gnt stays 0, all outputs at reset values next cycle.

Source files
------------

// File: rtl/xs_sched_pkg.sv
// Shared types and constants for the xorshift32 step scheduler:
// FSM encoding, seed padding and the hex-digit 7-segment table.
package xs_sched_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } fsm_t;

  // Upper seed bits; nonzero, so an expanded seed can never be the all-zero fixed point
  localparam logic [25:0] SEED_PAD = 26'h2545F49;

  // Active-high {g,f,e,d,c,b,a}, entry 15 first
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_of(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/xorshift32_next.sv
// One combinational xorshift32 round (13/17/5); shifted-out bits are dropped.
module xorshift32_next (
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [31:0] s1;
  logic [31:0] s2;

  assign s1 = x ^ (x << 13);
  assign s2 = s1 ^ (s1 >> 17);
  assign y  = s2 ^ (s2 << 5);

endmodule

// File: rtl/xorshift_step_scheduler.sv
// Controller around one xorshift32 datapath: seed load, warm-up, periodic tick,
// round-robin on-demand steps for two requesters, and a hex digit display.
module xorshift_step_scheduler
  import xs_sched_pkg::*;
#(
  parameter int unsigned MAX_COUNT     = 10_000_000,
  parameter int unsigned WARMUP_ROUNDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  seed,
  input  logic        reseed,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic [31:0] rnd,
  output logic        busy,
  output logic [6:0]  segments
);

  localparam int TICK_W = $clog2(MAX_COUNT);
  localparam int WARM_W = (WARMUP_ROUNDS > 1) ? $clog2(WARMUP_ROUNDS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MAX_COUNT - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_ROUNDS - 1);

  fsm_t              fsm_reg, fsm_next;
  logic [31:0]       state_reg;
  logic [31:0]       step_val;
  logic [TICK_W-1:0] tick_cnt_reg;
  logic [WARM_W-1:0] warm_cnt_reg;
  logic              rr_ptr_reg;
  logic [1:0]        gnt_reg;
  logic [31:0]       rnd_reg;
  logic [6:0]        seg_reg;

  logic [1:0]        elig;
  logic [1:0]        grant_next;
  logic              load_en;
  logic              step_en;
  logic              tick;

  xorshift32_next u_step (
    .x (state_reg),
    .y (step_val)
  );

  // A requester currently holding its grant is masked so one held request yields one grant
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = req[gi] & ~gnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) fsm_reg <= LOAD;
    else     fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      LOAD:    fsm_next = WARMUP;
      WARMUP:  fsm_next = (warm_cnt_reg == WARM_LAST) ? RUN : WARMUP;
      RUN:     fsm_next = reseed ? LOAD : RUN;
      default: fsm_next = LOAD;
    endcase
  end

  always_comb begin
    load_en    = 1'b0;
    step_en    = 1'b0;
    tick       = 1'b0;
    grant_next = 2'b00;
    case (fsm_reg)
      LOAD:   load_en = 1'b1;
      WARMUP: step_en = 1'b1;
      RUN: begin
        tick = (tick_cnt_reg == TICK_LAST);
        // Reseed pre-empts both the tick and any grant in the same cycle
        if (!reseed) begin
          if (elig == 2'b11) grant_next = rr_ptr_reg ? 2'b10 : 2'b01;
          else               grant_next = elig;
          step_en = tick || (grant_next != 2'b00);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      seg_reg   <= '0;
    end else begin
      if (load_en)      state_reg <= {SEED_PAD, seed};
      else if (step_en) state_reg <= step_val;
      if (step_en)      seg_reg   <= seg_of(step_val[3:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_reg    <= '0;
      rnd_reg    <= '0;
      rr_ptr_reg <= 1'b0;
    end else begin
      gnt_reg <= grant_next;
      if (grant_next != 2'b00) begin
        rnd_reg    <= step_val;
        rr_ptr_reg <= grant_next[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_reg <= '0;
      warm_cnt_reg <= '0;
    end else begin
      case (fsm_reg)
        LOAD: begin
          tick_cnt_reg <= '0;
          warm_cnt_reg <= '0;
        end
        WARMUP: warm_cnt_reg <= warm_cnt_reg + WARM_W'(1);
        RUN:    tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TICK_W'(1);
        default: ;
      endcase
    end
  end

  assign gnt      = gnt_reg;
  assign rnd      = rnd_reg;
  assign busy     = (fsm_reg != RUN);
  assign segments = seg_reg;

endmodule

// File: tb/tb_xorshift_step_scheduler.sv
// Directed bench for xorshift_step_scheduler with MAX_COUNT=100, WARMUP_ROUNDS=8.
module tb_xorshift_step_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  seed;
  logic        reseed;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [31:0] rnd;
  logic        busy;
  logic [6:0]  segments;

  int          checks = 0;
  int          failures = 0;
  int          r = 0;
  logic [31:0] exp_state = '0;
  logic [31:0] last_rnd = '0;
  logic [6:0]  seg_exp = '0;

  xorshift_step_scheduler #(
    .MAX_COUNT     (100),
    .WARMUP_ROUNDS (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seed     (seed),
    .reseed   (reseed),
    .req      (req),
    .gnt      (gnt),
    .rnd      (rnd),
    .busy     (busy),
    .segments (segments)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  // One RUN cycle; eg is the grant expected after this edge
  task automatic run_cycle(input logic [1:0] eg);
    tick_edge();
    r++;
    if (eg != 2'b00 || (r % 100) == 0) begin
      exp_state = xs(exp_state);
      seg_exp   = hexseg(exp_state[3:0]);
    end
    if (eg != 2'b00) last_rnd = exp_state;
    chk($sformatf("gnt@r%0d", r), 32'(gnt), 32'(eg));
    chk($sformatf("rnd@r%0d", r), rnd, last_rnd);
    chk($sformatf("seg@r%0d", r), 32'(segments), 32'(seg_exp));
    chk($sformatf("busy@r%0d", r), 32'(busy), 32'd0);
    if (eg != 2'b00)
      $display("grant r=%0d gnt=%b rnd=%h", r, gnt, rnd);
  endtask

  // Entered with the FSM in LOAD; leaves it one edge after the last warm-up step
  task automatic warm_phase(input logic [5:0] s);
    tick_edge();
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_gnt", 32'(gnt), 32'd0);
    chk("load_seg", 32'(segments), 32'(seg_exp));
    exp_state = {26'h2545F49, s};
    for (int k = 1; k <= 8; k++) begin
      tick_edge();
      exp_state = xs(exp_state);
      seg_exp   = hexseg(exp_state[3:0]);
      chk($sformatf("warm%0d_busy", k), 32'(busy), 32'(k < 8));
      chk($sformatf("warm%0d_seg", k), 32'(segments), 32'(seg_exp));
      chk($sformatf("warm%0d_gnt", k), 32'(gnt), 32'd0);
    end
    $display("warmup seed=%h done busy=%b seg=%h", s, busy, segments);
    r = 0;
  endtask

  initial begin
    rst = 1'b1; seed = 6'h00; reseed = 1'b0; req = 2'b00;

    for (int i = 0; i < 3; i++) begin
      tick_edge();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rnd", rnd, 32'd0);
      chk("rst_seg", 32'(segments), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      $display("reset cycle %0d busy=%b seg=%h", i, busy, segments);
    end
    rst = 1'b0;
    warm_phase(6'h00);

    // Free-running ticks over 1000 RUN cycles
    for (int i = 0; i < 1000; i++) run_cycle(2'b00);

    // Both requesting: requester 0 first, then requester 1
    req = 2'b11;
    run_cycle(2'b01);
    req = 2'b10;
    run_cycle(2'b10);
    req = 2'b00;
    run_cycle(2'b00);

    // Held single request: grant on alternate cycles only
    req = 2'b01;
    run_cycle(2'b01);
    run_cycle(2'b00);
    run_cycle(2'b01);
    run_cycle(2'b00);
    req = 2'b00;
    run_cycle(2'b00);

    // Request coinciding with the tick wrap
    while (r < 1099) run_cycle(2'b00);
    req = 2'b10;
    run_cycle(2'b10);
    req = 2'b00;
    while (r < 1210) run_cycle(2'b00);

    // Reseed beats a simultaneous request; the request is served after warm-up
    seed = 6'h3F; reseed = 1'b1; req = 2'b01;
    tick_edge();
    chk("reseed_gnt", 32'(gnt), 32'd0);
    chk("reseed_busy", 32'(busy), 32'd1);
    chk("reseed_rnd", rnd, last_rnd);
    chk("reseed_seg", 32'(segments), 32'(seg_exp));
    $display("reseed gnt=%b busy=%b", gnt, busy);
    reseed = 1'b0;
    warm_phase(6'h3F);
    run_cycle(2'b01);
    req = 2'b00;
    run_cycle(2'b00);
    run_cycle(2'b00);

    // Reset on the cycle a grant would fire
    req = 2'b10; rst = 1'b1;
    tick_edge();
    chk("rstgnt_gnt", 32'(gnt), 32'd0);
    chk("rstgnt_rnd", rnd, 32'd0);
    chk("rstgnt_seg", 32'(segments), 32'd0);
    chk("rstgnt_busy", 32'(busy), 32'd1);
    $display("reset-on-grant gnt=%b rnd=%h busy=%b", gnt, rnd, busy);
    rst = 1'b0; req = 2'b00;
    tick_edge();
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_gnt", 32'(gnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
